// File: rtl/riscv_fetch_decode.sv
// rtl/riscv_fetch_decode.sv - RV32I fetch/decode front end with fetch queue, redirect and immediate generation
module riscv_fetch_decode #(
    parameter int              XLEN      = 32,
    parameter int              FQ_DEPTH  = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [XLEN-1:0]             imem_req_addr,
    input  logic                        imem_rsp_valid,
    input  logic [31:0]                 imem_rsp_data,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    input  logic                        stall_in,
    output logic                        dec_valid,
    output logic [XLEN-1:0]             dec_pc,
    output logic [6:0]                  dec_opcode,
    output logic [4:0]                  dec_rd,
    output logic [4:0]                  dec_rs1,
    output logic [4:0]                  dec_rs2,
    output logic [2:0]                  dec_funct3,
    output logic [6:0]                  dec_funct7,
    output logic [XLEN-1:0]             dec_imm,
    output logic                        dec_illegal,
    output logic [$clog2(FQ_DEPTH):0]   fq_count
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int FW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    // PC generation and in-flight bookkeeping
    logic [XLEN-1:0] r_pc;
    logic [OW-1:0]   r_outst;
    logic [OW-1:0]   r_drop;

    // Addresses of in-flight requests, consumed in order by responses
    logic [XLEN-1:0] r_pf_pc [MAX_OUTST];
    logic [FW-1:0]   r_pf_rd;
    logic [FW-1:0]   r_pf_wr;

    // Fetch queue
    logic [31:0]     r_fq_instr [FQ_DEPTH];
    logic [XLEN-1:0] r_fq_pc    [FQ_DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    // Decode bundle
    logic            r_dec_valid;
    logic [XLEN-1:0] r_dec_pc;
    logic [31:0]     r_dec_instr;
    logic [XLEN-1:0] r_dec_imm;
    logic            r_dec_illegal;

    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_rsp_drop;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_rsp_pc;
    logic [XLEN-1:0] w_redirect_pc;
    logic [31:0]     w_instr;
    logic [31:0]     w_imm32;
    logic            w_illegal;

    function automatic logic [FW-1:0] pf_next(input logic [FW-1:0] p);
        if (int'(p) == MAX_OUTST - 1) return '0;
        else return p + FW'(1);
    endfunction

    // Credit: queue slots already used plus responses still owed must leave room
    assign w_req_valid   = !rst && ((int'(r_count) + int'(r_outst)) < FQ_DEPTH)
                                && (int'(r_outst) < MAX_OUTST);
    assign w_req_fire    = w_req_valid && imem_req_ready;
    assign w_rsp_drop    = imem_rsp_valid && ((r_drop != '0) || redirect_valid);
    assign w_push        = imem_rsp_valid && !w_rsp_drop;
    assign w_pop         = (!r_dec_valid || !stall_in) && (r_count != '0) && !redirect_valid;
    assign w_rsp_pc      = r_pf_pc[r_pf_rd];
    assign w_redirect_pc = redirect_pc & ~XLEN'(3);
    assign w_instr       = r_fq_instr[r_rd_ptr];

    // Immediate generation and legality check for the queue head
    always_comb begin
        w_imm32   = '0;
        w_illegal = 1'b0;
        case (w_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111:
                w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
            7'b0100011:
                w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            7'b1100011:
                w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                           w_instr[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                w_imm32 = {w_instr[31:12], 12'b0};
            7'b1101111:
                w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                           w_instr[30:21], 1'b0};
            7'b0110011, 7'b1110011, 7'b0001111:
                w_imm32 = '0;
            default:
                w_illegal = 1'b1;
        endcase
    end

    // PC, outstanding count, drop count and queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_outst  <= '0;
            r_drop   <= '0;
            r_pf_rd  <= '0;
            r_pf_wr  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_outst <= r_outst + OW'(w_req_fire) - OW'(imem_rsp_valid);
            if (w_req_fire) r_pf_wr <= pf_next(r_pf_wr);
            if (imem_rsp_valid) r_pf_rd <= pf_next(r_pf_rd);

            if (redirect_valid) begin
                r_pc     <= w_redirect_pc;
                // Everything still owed by memory belongs to the old path
                r_drop   <= r_outst - OW'(imem_rsp_valid) + OW'(w_req_fire);
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_req_fire) r_pc <= r_pc + XLEN'(4);
                if (imem_rsp_valid && (r_drop != '0)) r_drop <= r_drop - OW'(1);
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // Storage for queue entries and in-flight request addresses
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fq_instr[r_wr_ptr] <= imem_rsp_data;
            r_fq_pc[r_wr_ptr]    <= w_rsp_pc;
        end
        if (w_req_fire) r_pf_pc[r_pf_wr] <= r_pc;
    end

    // Decode register: load from queue head, hold under stall, clear on redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_valid   <= 1'b0;
            r_dec_pc      <= '0;
            r_dec_instr   <= '0;
            r_dec_imm     <= '0;
            r_dec_illegal <= 1'b0;
        end else if (redirect_valid) begin
            r_dec_valid <= 1'b0;
        end else if (w_pop) begin
            r_dec_valid   <= 1'b1;
            r_dec_pc      <= r_fq_pc[r_rd_ptr];
            r_dec_instr   <= w_instr;
            r_dec_imm     <= XLEN'($signed(w_imm32));
            r_dec_illegal <= w_illegal;
        end else if (!stall_in) begin
            r_dec_valid <= 1'b0;
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign dec_valid      = r_dec_valid;
    assign dec_pc         = r_dec_pc;
    assign dec_opcode     = r_dec_instr[6:0];
    assign dec_rd         = r_dec_instr[11:7];
    assign dec_funct3     = r_dec_instr[14:12];
    assign dec_rs1        = r_dec_instr[19:15];
    assign dec_rs2        = r_dec_instr[24:20];
    assign dec_funct7     = r_dec_instr[31:25];
    assign dec_imm        = r_dec_imm;
    assign dec_illegal    = r_dec_illegal;
    assign fq_count       = r_count;

endmodule

// File: tb/tb_riscv_fetch_decode.sv
// tb/tb_riscv_fetch_decode.sv - directed bench for riscv_fetch_decode
module tb_riscv_fetch_decode;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, rsp_valid, redir_valid, stall_in;
    logic [31:0] req_addr, rsp_data, redir_pc;
    logic        dec_valid, dec_illegal;
    logic [31:0] dec_pc, dec_imm;
    logic [6:0]  dec_opcode, dec_funct7;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [2:0]  dec_funct3;
    logic [2:0]  fq_count;

    logic        req2_valid, rsp2_valid, stall2;
    logic [31:0] req2_addr, rsp2_data, dec2_pc, dec2_imm;
    logic        dec2_valid, dec2_illegal;
    logic [6:0]  dec2_opcode, dec2_funct7;
    logic [4:0]  dec2_rd, dec2_rs1, dec2_rs2;
    logic [2:0]  dec2_funct3;
    logic [1:0]  fq2_count;

    riscv_fetch_decode #(.XLEN(32), .FQ_DEPTH(4), .MAX_OUTST(2), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect_valid(redir_valid), .redirect_pc(redir_pc), .stall_in(stall_in),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_opcode(dec_opcode), .dec_rd(dec_rd),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_funct3(dec_funct3), .dec_funct7(dec_funct7),
        .dec_imm(dec_imm), .dec_illegal(dec_illegal), .fq_count(fq_count)
    );

    riscv_fetch_decode #(.XLEN(32), .FQ_DEPTH(2), .MAX_OUTST(2), .RESET_PC(32'h0)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req_valid(req2_valid), .imem_req_ready(1'b1), .imem_req_addr(req2_addr),
        .imem_rsp_valid(rsp2_valid), .imem_rsp_data(rsp2_data),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .stall_in(stall2),
        .dec_valid(dec2_valid), .dec_pc(dec2_pc), .dec_opcode(dec2_opcode), .dec_rd(dec2_rd),
        .dec_rs1(dec2_rs1), .dec_rs2(dec2_rs2), .dec_funct3(dec2_funct3), .dec_funct7(dec2_funct7),
        .dec_imm(dec2_imm), .dec_illegal(dec2_illegal), .fq_count(fq2_count)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat = 1;
    bit          mem_mode = 1'b0;
    logic [31:0] mem_fixed = 32'hFFF00093;
    logic [31:0] exp_pc;

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          cyc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_mode) return {a[11:0], 20'h00093};
        return mem_fixed;
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] pc);
        if (mem_mode) return {{20{pc[11]}}, pc[11:0]};
        return 32'hFFFFFFFF;
    endfunction

    // In-order memory with programmable latency; cleared by reset
    always @(posedge clk) begin
        if (rst) begin
            mq_addr.delete();
            mq_due.delete();
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (req_valid && req_ready) begin
                mq_addr.push_back(req_addr);
                mq_due.push_back(cyc + lat - 1);
            end
            if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                rsp_valid <= 1'b1;
                rsp_data  <= mem_word(mq_addr[0]);
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end else begin
                rsp_valid <= 1'b0;
            end
        end
        cyc++;
    end

    // Single-cycle memory for the shallow-queue instance
    always @(posedge clk) begin
        if (rst) begin
            rsp2_valid <= 1'b0;
            rsp2_data  <= '0;
        end else begin
            rsp2_valid <= req2_valid;
            rsp2_data  <= {req2_addr[11:0], 20'h00093};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int outst();
        return mq_addr.size() + (rsp_valid ? 1 : 0);
    endfunction

    task automatic collect(input int n);
        int got = 0;
        int budget = 0;
        while (got < n && budget < 200) begin
            if (dec_valid && !stall_in) begin
                chk("stream_pc", dec_pc, exp_pc);
                chk("stream_imm", dec_imm, exp_imm(exp_pc));
                exp_pc += 32'd4;
                got++;
            end
            @(negedge clk);
            budget++;
        end
        if (got < n) chk("collect_timeout", got, n);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic        ill;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int b;
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 1'b0, 5'd1};
        vecs[1]  = '{32'h800000EF, 32'hFFF00000, 1'b0, 5'd1};
        vecs[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 1'b0, 5'd29};
        vecs[3]  = '{32'h123450B7, 32'h12345000, 1'b0, 5'd1};
        vecs[4]  = '{32'h0000007F, 32'h00000000, 1'b1, 5'd0};
        vecs[5]  = '{32'hFE20AC23, 32'hFFFFFFF8, 1'b0, 5'd24};
        vecs[6]  = '{32'h002081B3, 32'h00000000, 1'b0, 5'd3};
        vecs[7]  = '{32'hFFFFF097, 32'hFFFFF000, 1'b0, 5'd1};
        vecs[8]  = '{32'h00000073, 32'h00000000, 1'b0, 5'd0};
        vecs[9]  = '{32'h0FF0000F, 32'h00000000, 1'b0, 5'd0};
        vecs[10] = '{32'h80008067, 32'hFFFFF800, 1'b0, 5'd0};
        vecs[11] = '{32'h7FF0A083, 32'h000007FF, 1'b0, 5'd1};
        vecs[12] = '{32'h0000005B, 32'h00000000, 1'b1, 5'd0};

        rst = 1'b1; req_ready = 1'b1; redir_valid = 1'b0; redir_pc = '0;
        stall_in = 1'b0; stall2 = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_addr", req_addr, 32'h100);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_dec_pc", dec_pc, 0);
        chk("rst_dec_imm", dec_imm, 0);
        chk("rst_dec_illegal", dec_illegal, 0);
        chk("rst_dec_opcode", dec_opcode, 0);
        chk("rst_fq_count", fq_count, 0);
        rst = 1'b0;
        #1;
        chk("first_req_valid", req_valid, 1);
        chk("first_req_addr", req_addr, 32'h100);

        // Streaming, back to back
        exp_pc = 32'h100;
        b = 0;
        while (!dec_valid && b < 20) begin @(negedge clk); b++; end
        for (int k = 0; k < 6; k++) begin
            chk("b2b_valid", dec_valid, 1);
            chk("b2b_pc", dec_pc, exp_pc);
            chk("b2b_rd", dec_rd, 1);
            chk("b2b_imm", dec_imm, 32'hFFFFFFFF);
            exp_pc += 32'd4;
            @(negedge clk);
        end

        // Back-pressure
        stall_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid", dec_valid, 1);
            chk("stall_pc", dec_pc, exp_pc);
            chk("stall_credit", (int'(fq_count) + outst()) <= 4, 1);
            @(negedge clk);
        end
        chk("stall_fq_full", fq_count, 4);
        chk("stall_no_req", req_valid, 0);
        stall_in = 1'b0;
        collect(8);

        // Redirect with two requests in flight
        lat = 3;
        b = 0;
        while (outst() != 2 && b < 20) begin @(negedge clk); b++; end
        chk("two_inflight", outst(), 2);
        mem_mode = 1'b1;
        redir_valid = 1'b1; redir_pc = 32'h203;
        @(negedge clk);
        redir_valid = 1'b0;
        chk("redir_addr", req_addr, 32'h200);
        chk("redir_dec_valid", dec_valid, 0);
        chk("redir_fq_count", fq_count, 0);
        exp_pc = 32'h200;
        collect(6);

        // Immediate / decode table
        lat = 1;
        mem_mode = 1'b0;
        for (int i = 0; i < 13; i++) begin
            mem_fixed = vecs[i].instr;
            redir_valid = 1'b1; redir_pc = 32'h400;
            @(negedge clk);
            redir_valid = 1'b0;
            b = 0;
            while (!dec_valid && b < 20) begin @(negedge clk); b++; end
            chk("vec_valid", dec_valid, 1);
            chk("vec_pc", dec_pc, 32'h400);
            chk("vec_opcode", dec_opcode, vecs[i].instr[6:0]);
            chk("vec_rd", dec_rd, vecs[i].rd);
            chk("vec_imm", dec_imm, vecs[i].imm);
            chk("vec_illegal", dec_illegal, vecs[i].ill);
        end

        // PC wrap
        mem_mode = 1'b1;
        redir_valid = 1'b1; redir_pc = 32'hFFFFFFFC;
        @(negedge clk);
        redir_valid = 1'b0;
        chk("wrap_addr0", req_addr, 32'hFFFFFFFC);
        b = 0;
        while (!req_valid && b < 10) begin @(negedge clk); b++; end
        chk("wrap_req_valid", req_valid, 1);
        @(negedge clk);
        chk("wrap_addr1", req_addr, 32'h0);
        exp_pc = 32'hFFFFFFFC;
        collect(3);

        // Shallow queue: saturate at two, then drain in order
        chk("fq2_full", fq2_count, 2);
        chk("fq2_no_req", req2_valid, 0);
        chk("fq2_hold_pc", dec2_pc, 0);
        stall2 = 1'b0;
        begin
            logic [31:0] e2 = 32'h0;
            int got = 0;
            b = 0;
            while (got < 8 && b < 100) begin
                chk("fq2_bound", fq2_count <= 2, 1);
                if (dec2_valid) begin
                    chk("fq2_pc", dec2_pc, e2);
                    chk("fq2_imm", dec2_imm, e2);
                    e2 += 32'd4;
                    got++;
                end
                @(negedge clk);
                b++;
            end
            if (got < 8) chk("fq2_timeout", got, 8);
        end

        // Reset in mid-operation
        lat = 3;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mrst_dec_valid", dec_valid, 0);
        chk("mrst_fq_count", fq_count, 0);
        chk("mrst_req_valid", req_valid, 0);
        chk("mrst_req_addr", req_addr, 32'h100);
        rst = 1'b0;
        exp_pc = 32'h100;
        collect(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
